// File: rtl/enigma_cmd_decoder.sv
// Enigma front-end command decoder.
// Decodes one 16-bit switch word per rising edge of data_valid_in into staged
// rotor position/select writes, atomic commit/clear, and letter submissions.
// Letters are buffered in a show-ahead FIFO and handed downstream over a
// valid/ready handshake. Rejected commands pulse err_out with a reason code.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   data_valid_in     command strobe; rising edge = one command
//   sw                command word (opcode in [15:13])
//   char_ready_in     downstream ready for char_out
//   rotor_select_out  committed selects, rotor i at [i*SEL_W +: SEL_W]
//   rotor_initial_out committed start positions, rotor i at [i*5 +: 5]
//   config_valid_out  one-cycle pulse on a legal commit
//   configured_out    high once any commit has occurred since reset
//   char_out          FIFO head letter (0 when empty)
//   char_valid_out    FIFO non-empty
//   fifo_count_out    entries held
//   err_out           one-cycle pulse on a rejected command
//   err_code_out      reason of the last rejection, held
module enigma_cmd_decoder #(
  parameter int unsigned NUM_ROTORS = 3,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          data_valid_in,
  input  logic [15:0]                   sw,
  input  logic                          char_ready_in,
  output logic [NUM_ROTORS*SEL_W-1:0]   rotor_select_out,
  output logic [NUM_ROTORS*5-1:0]       rotor_initial_out,
  output logic                          config_valid_out,
  output logic                          configured_out,
  output logic [4:0]                    char_out,
  output logic                          char_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          err_out,
  output logic [1:0]                    err_code_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SEL_V = NUM_ROTORS * SEL_W;
  localparam int unsigned POS_V = NUM_ROTORS * 5;

  localparam logic [2:0] OP_SET_POS = 3'b000;
  localparam logic [2:0] OP_SET_SEL = 3'b001;
  localparam logic [2:0] OP_COMMIT  = 3'b010;
  localparam logic [2:0] OP_CLEAR   = 3'b011;

  localparam logic [1:0] ERR_RANGE  = 2'd0;
  localparam logic [1:0] ERR_UNCONF = 2'd1;
  localparam logic [1:0] ERR_FULL   = 2'd2;
  localparam logic [1:0] ERR_BUSY   = 2'd3;

  // Registered state
  logic                 dv_q;
  logic [SEL_V-1:0]     stg_sel_q, stg_sel_d;
  logic [POS_V-1:0]     stg_pos_q, stg_pos_d;
  logic [SEL_V-1:0]     sel_q, sel_d;
  logic [POS_V-1:0]     pos_q, pos_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic                 configured_q, configured_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [4:0]           mem_q [FIFO_DEPTH];

  // Decode helpers
  logic       cmd_fire;
  logic [2:0] opcode;
  logic [2:0] idx;
  logic [4:0] val5;
  logic       idx_bad;
  logic       val_bad;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       unused_sw;

  assign cmd_fire   = data_valid_in && !dv_q;
  assign opcode     = sw[15:13];
  assign idx        = sw[12:10];
  assign val5       = sw[4:0];
  assign idx_bad    = {1'b0, idx} >= 4'(NUM_ROTORS);
  assign val_bad    = val5 > 5'd25;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && char_ready_in;
  assign unused_sw  = ^sw[9:5];

  // Command decode, error arbitration and FIFO bookkeeping
  always_comb begin
    stg_sel_d    = stg_sel_q;
    stg_pos_d    = stg_pos_q;
    sel_d        = sel_q;
    pos_d        = pos_q;
    cfg_valid_d  = 1'b0;
    configured_d = configured_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    push         = 1'b0;

    if (cmd_fire) begin
      if (opcode[2]) begin
        // Letter: range, then configured, then capacity (a same-cycle pop frees a slot)
        if (val_bad) begin
          err_d      = 1'b1;
          err_code_d = ERR_RANGE;
        end else if (!configured_q) begin
          err_d      = 1'b1;
          err_code_d = ERR_UNCONF;
        end else if (fifo_full && !pop) begin
          err_d      = 1'b1;
          err_code_d = ERR_FULL;
        end else begin
          push = 1'b1;
        end
      end else begin
        case (opcode)
          OP_SET_POS: begin
            if (idx_bad || val_bad) begin
              err_d      = 1'b1;
              err_code_d = ERR_RANGE;
            end else begin
              for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
                if (32'(idx) == i) stg_pos_d[i*5 +: 5] = val5;
              end
            end
          end
          OP_SET_SEL: begin
            if (idx_bad) begin
              err_d      = 1'b1;
              err_code_d = ERR_RANGE;
            end else begin
              for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
                if (32'(idx) == i) stg_sel_d[i*SEL_W +: SEL_W] = sw[SEL_W-1:0];
              end
            end
          end
          OP_COMMIT: begin
            // Refuse to reconfigure while letters of the current message are queued
            if (!fifo_empty) begin
              err_d      = 1'b1;
              err_code_d = ERR_BUSY;
            end else begin
              sel_d        = stg_sel_q;
              pos_d        = stg_pos_q;
              cfg_valid_d  = 1'b1;
              configured_d = 1'b1;
            end
          end
          OP_CLEAR: begin
            stg_sel_d = '0;
            stg_pos_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // FIFO pointer/count next state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    if (push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (push && !pop)      count_d = CNT_W'(count_q + 1'b1);
    else if (pop && !push) count_d = CNT_W'(count_q - 1'b1);
  end

  // State registers; edge history resets high so a held strobe does not fire
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dv_q         <= 1'b1;
      stg_sel_q    <= '0;
      stg_pos_q    <= '0;
      sel_q        <= '0;
      pos_q        <= '0;
      cfg_valid_q  <= 1'b0;
      configured_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      dv_q         <= data_valid_in;
      stg_sel_q    <= stg_sel_d;
      stg_pos_q    <= stg_pos_d;
      sel_q        <= sel_d;
      pos_q        <= pos_d;
      cfg_valid_q  <= cfg_valid_d;
      configured_q <= configured_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Letter storage; when full with a simultaneous pop the write lands in the slot being vacated
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= val5;
    end
  end

  assign rotor_select_out  = sel_q;
  assign rotor_initial_out = pos_q;
  assign config_valid_out  = cfg_valid_q;
  assign configured_out    = configured_q;
  assign char_valid_out    = !fifo_empty;
  assign char_out          = fifo_empty ? 5'd0 : mem_q[rd_ptr_q];
  assign fifo_count_out    = count_q;
  assign err_out           = err_q;
  assign err_code_out      = err_code_q;

endmodule

// File: tb/tb_enigma_cmd_decoder.sv
// Directed self-checking bench for enigma_cmd_decoder (default parameters).
module tb_enigma_cmd_decoder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        data_valid_in;
  logic [15:0] sw;
  logic        char_ready_in;
  logic [8:0]  rotor_select_out;
  logic [14:0] rotor_initial_out;
  logic        config_valid_out;
  logic        configured_out;
  logic [4:0]  char_out;
  logic        char_valid_out;
  logic [3:0]  fifo_count_out;
  logic        err_out;
  logic [1:0]  err_code_out;

  int checks = 0;
  int errors = 0;

  enigma_cmd_decoder #(.NUM_ROTORS(3), .SEL_W(3), .FIFO_DEPTH(8)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .data_valid_in    (data_valid_in),
    .sw               (sw),
    .char_ready_in    (char_ready_in),
    .rotor_select_out (rotor_select_out),
    .rotor_initial_out(rotor_initial_out),
    .config_valid_out (config_valid_out),
    .configured_out   (configured_out),
    .char_out         (char_out),
    .char_valid_out   (char_valid_out),
    .fifo_count_out   (fifo_count_out),
    .err_out          (err_out),
    .err_code_out     (err_code_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise the strobe with a command; return #1 after the edge that executes it
  task automatic send(input logic [15:0] cmd);
    @(negedge clk_in);
    sw = cmd;
    data_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  // Drop the strobe for one edge so the next send is a fresh rising edge
  task automatic release_dv();
    @(negedge clk_in);
    data_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  logic [4:0] exp_order [8];

  initial begin
    rst_in = 1'b1;
    data_valid_in = 1'b1;
    sw = 16'h4000;
    char_ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Strobe held high through and after reset: nothing fires
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1;
      check("held_err", 32'(err_out), 32'd0);
      check("held_cfgv", 32'(config_valid_out), 32'd0);
    end
    check("rst_sel", 32'(rotor_select_out), 32'd0);
    check("rst_pos", 32'(rotor_initial_out), 32'd0);
    check("rst_configured", 32'(configured_out), 32'd0);
    check("rst_count", 32'(fifo_count_out), 32'd0);
    check("rst_cvalid", 32'(char_valid_out), 32'd0);
    check("rst_char", 32'(char_out), 32'd0);
    check("rst_code", 32'(err_code_out), 32'd0);
    release_dv();

    // Letter before any commit -> code 1
    send(16'h8007);
    check("unconf_err", 32'(err_out), 32'd1);
    check("unconf_code", 32'(err_code_out), 32'd1);
    check("unconf_count", 32'(fifo_count_out), 32'd0);
    release_dv();
    check("err_pulse_end", 32'(err_out), 32'd0);
    check("code_held", 32'(err_code_out), 32'd1);

    // SET_POS with index 5 -> code 0
    send(16'h1400);
    check("idx_err", 32'(err_out), 32'd1);
    check("idx_code", 32'(err_code_out), 32'd0);
    release_dv();

    // Stage positions and selects, then commit
    send(16'h0003); release_dv();
    send(16'h0411); release_dv();
    send(16'h0819); release_dv();
    send(16'h2001); release_dv();
    send(16'h2404); release_dv();
    send(16'h2802);
    check("stage_no_err", 32'(err_out), 32'd0);
    check("stage_pos_unseen", 32'(rotor_initial_out), 32'd0);
    release_dv();
    send(16'h4000);
    check("commit_pulse", 32'(config_valid_out), 32'd1);
    check("commit_pos", 32'(rotor_initial_out), 32'({5'd25, 5'd17, 5'd3}));
    check("commit_sel", 32'(rotor_select_out), 32'({3'd2, 3'd4, 3'd1}));
    check("commit_configured", 32'(configured_out), 32'd1);
    check("commit_no_err", 32'(err_out), 32'd0);
    release_dv();
    check("commit_pulse_end", 32'(config_valid_out), 32'd0);

    // Letter 30 -> code 0
    send(16'h801E);
    check("letter_range_err", 32'(err_out), 32'd1);
    check("letter_range_code", 32'(err_code_out), 32'd0);
    check("letter_range_count", 32'(fifo_count_out), 32'd0);
    release_dv();

    // Fill with ready low; 9th letter -> code 2
    for (int i = 0; i < 9; i++) begin
      send(16'h8000 | 16'(i));
      if (i < 8) begin
        check("fill_no_err", 32'(err_out), 32'd0);
        check("fill_count", 32'(fifo_count_out), 32'(i + 1));
        check("fill_valid", 32'(char_valid_out), 32'd1);
      end else begin
        check("full_err", 32'(err_out), 32'd1);
        check("full_code", 32'(err_code_out), 32'd2);
        check("full_count", 32'(fifo_count_out), 32'd8);
      end
      release_dv();
    end
    check("full_head", 32'(char_out), 32'd0);

    // Full: push 12 on the same edge as a pop
    @(negedge clk_in);
    char_ready_in = 1'b1;
    sw = 16'h800C;
    data_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("pushpop_no_err", 32'(err_out), 32'd0);
    check("pushpop_count", 32'(fifo_count_out), 32'd8);
    @(negedge clk_in);
    char_ready_in = 1'b0;
    data_valid_in = 1'b0;
    check("pushpop_head", 32'(char_out), 32'd1);

    // Drain in order
    exp_order = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd12};
    @(negedge clk_in);
    char_ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_char", 32'(char_out), 32'(exp_order[k]));
      check("drain_valid", 32'(char_valid_out), 32'd1);
      check("drain_count", 32'(fifo_count_out), 32'(8 - k));
      @(negedge clk_in);
    end
    check("drained_valid", 32'(char_valid_out), 32'd0);
    check("drained_char", 32'(char_out), 32'd0);
    check("drained_count", 32'(fifo_count_out), 32'd0);
    char_ready_in = 1'b0;

    // Two queued letters block a commit
    send(16'h8003); release_dv();
    send(16'h8004); release_dv();
    send(16'h4000);
    check("busy_err", 32'(err_out), 32'd1);
    check("busy_code", 32'(err_code_out), 32'd3);
    check("busy_no_pulse", 32'(config_valid_out), 32'd0);
    check("busy_pos", 32'(rotor_initial_out), 32'({5'd25, 5'd17, 5'd3}));
    check("busy_count", 32'(fifo_count_out), 32'd2);
    release_dv();
    @(negedge clk_in);
    check("q_head0", 32'(char_out), 32'd3);
    char_ready_in = 1'b1;
    @(negedge clk_in);
    check("q_head1", 32'(char_out), 32'd4);
    @(negedge clk_in);
    check("q_empty", 32'(char_valid_out), 32'd0);
    char_ready_in = 1'b0;

    // CLEAR leaves outputs alone; following COMMIT zeroes them
    send(16'h6000);
    check("clear_no_err", 32'(err_out), 32'd0);
    check("clear_pos_kept", 32'(rotor_initial_out), 32'({5'd25, 5'd17, 5'd3}));
    check("clear_sel_kept", 32'(rotor_select_out), 32'({3'd2, 3'd4, 3'd1}));
    release_dv();
    send(16'h4000);
    check("zero_commit_pulse", 32'(config_valid_out), 32'd1);
    check("zero_commit_pos", 32'(rotor_initial_out), 32'd0);
    check("zero_commit_sel", 32'(rotor_select_out), 32'd0);
    check("zero_configured", 32'(configured_out), 32'd1);
    release_dv();
    send(16'h4000);
    check("b2b_commit_pulse", 32'(config_valid_out), 32'd1);
    release_dv();

    // Reset mid-operation flushes the FIFO and clears configuration
    send(16'h8009); release_dv();
    check("pre_rst_count", 32'(fifo_count_out), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    char_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("mid_rst_count", 32'(fifo_count_out), 32'd0);
    check("mid_rst_configured", 32'(configured_out), 32'd0);
    check("mid_rst_valid", 32'(char_valid_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    char_ready_in = 1'b0;
    send(16'h8005);
    check("post_rst_unconf", 32'(err_code_out), 32'd1);
    release_dv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/enigma_cmd_decoder.md
Name: enigma_cmd_decoder

Overview:
Parametrised front-end command decoder for the Enigma datapath. It decodes switch words on each rising edge of the data-valid strobe into per-rotor position and select writes, config commit and clear commands, and letter submissions. Rotor configuration is staged, then committed atomically to the rotor bank. Letters are buffered in a FIFO and released to the encryption core over a valid/ready handshake, with error reporting for malformed or illegal commands.

Parameters:
NUM_ROTORS, 3, number of rotors configured (1..8)
SEL_W, 3, rotor-select field width per rotor (1..8)
FIFO_DEPTH, 8, letter FIFO entries (power of two, >=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
data_valid_in  input  1  command strobe (level; rising edge = one command)
sw  input  16  command word
char_ready_in  input  1  downstream ready for char_out
rotor_select_out  output  NUM_ROTORS*SEL_W  committed selects; rotor i at [i*SEL_W +: SEL_W]
rotor_initial_out  output  NUM_ROTORS*5  committed start positions; rotor i at [i*5 +: 5]
config_valid_out  output  1  one-cycle pulse on commit
configured_out  output  1  level; high once any commit has occurred since reset
char_out  output  5  FIFO head letter (0..25)
char_valid_out  output  1  FIFO non-empty
fifo_count_out  output  $clog2(FIFO_DEPTH)+1  entries held
err_out  output  1  one-cycle pulse on rejected command
err_code_out  output  2  reason, held until next error

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset: all outputs 0; staged selects/positions 0; FIFO empty; edge-detect history register resets to 1, so a strobe held high through reset does not fire.
- Command accepted only on the cycle where data_valid_in=1 and the previous sample was 0. Effects are visible on outputs the next cycle.
- Opcode sw[15:13]:
  - 000 SET_POS: rotor index sw[12:10], position sw[4:0] -> staged position.
  - 001 SET_SEL: rotor index sw[12:10], select sw[SEL_W-1:0] -> staged select.
  - 010 COMMIT: staged -> output registers. Pulses config_valid_out; sets configured_out=1.
  - 011 CLEAR: staged -> 0. Outputs are unchanged.
  - 1xx LETTER: sw[4:0] pushed to FIFO.
- Error codes (err_out pulses for 1 cycle; the command has no other effect):
  - 0: index >= NUM_ROTORS, or position/letter > 25.
  - 1: LETTER while configured_out=0.
  - 2: LETTER while FIFO full and no pop in the same cycle.
  - 3: COMMIT while FIFO non-empty. This prevents reconfiguring mid-message.
- Only one error is reported per command. Priority order: 0, 1, 2, 3.
- FIFO is show-ahead: char_out is the head entry, and char_valid_out = (count != 0).
  - Pop when char_valid_out && char_ready_in.
  - Push and pop in the same cycle: count unchanged. This is legal when full.
  - When empty, char_out=0. Pointers wrap modulo FIFO_DEPTH.
- Latency for a letter into an empty FIFO: char_valid_out rises 1 cycle after the edge cycle.
- config_valid_out never pulses without a legal COMMIT. Back-to-back COMMITs each pulse.
- rst_in during operation: the FIFO is flushed and all state returns to its reset values on the next edge, regardless of the handshake in progress.

Test Plan:
- Reset with data_valid_in held high, then keep it high for 5 cycles -> no command executes, no err_out, all outputs 0.
- SET_POS r0=3, r1=17, r2=25; SET_SEL r0=1, r1=4, r2=2; COMMIT -> config_valid_out pulses 1 cycle, rotor_initial_out={25,17,3}, rotor_select_out={2,4,1}, configured_out=1.
- LETTER 7 before any COMMIT -> err_out with code 1, count stays 0. SET_POS index 5 (NUM_ROTORS=3) -> code 0. LETTER 30 after commit -> code 0.
- With char_ready_in=0, push 9 letters (0..8) -> count reaches 8, 9th gives code 2. Then raise ready -> chars 0..7 emerge in order, one per cycle, and char_valid_out drops after the last.
- FIFO full, char_ready_in=1, LETTER 12 on the same cycle as a pop -> accepted, no error, count stays 8, and 12 emerges last.
- Two letters queued, COMMIT -> code 3 and outputs unchanged. Drain the FIFO, then CLEAR and COMMIT -> outputs all 0 and config_valid_out pulses.
